restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 122 ++++++++++++
 tb/tb_restoring_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - multi-cycle restoring divider, 2*WIDTH dividend by WIDTH divisor.
// Define RESTORING_DIV_SIGNED_EN for two's-complement operands with truncating results.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] z,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] q,
  output logic [WIDTH-1:0]   r,
  output logic               busy,
  output logic               done,
  output logic               dz
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(2*WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(2*WIDTH-1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [2*WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0]   r_div;

  logic [2*WIDTH-1:0] w_zmag;
  logic [WIDTH-1:0]   w_ymag;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rnext;
  logic [2*WIDTH-1:0] w_qnext;
  logic [2*WIDTH-1:0] w_qfin;
  logic [WIDTH-1:0]   w_rfin;

  // r_dvd doubles as the quotient shift register: dividend bits leave the top as quotient bits enter the bottom
  assign w_shift = {r_rem, r_dvd[2*WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_rnext = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_qnext = {r_dvd[2*WIDTH-2:0], w_ge};

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

`ifdef RESTORING_DIV_SIGNED_EN
  logic r_qneg;
  logic r_rneg;

  // the datapath only ever sees magnitudes; the most-negative dividend maps onto its own unsigned value
  assign w_zmag = z[2*WIDTH-1] ? -z : z;
  assign w_ymag = y[WIDTH-1]   ? -y : y;
  assign w_qfin = r_qneg ? -w_qnext : w_qnext;
  assign w_rfin = r_rneg ? -w_rnext : w_rnext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_qneg <= z[2*WIDTH-1] ^ y[WIDTH-1];
      r_rneg <= z[2*WIDTH-1];
    end
  end
`else
  assign w_zmag = z;
  assign w_ymag = y;
  assign w_qfin = w_qnext;
  assign w_rfin = w_rnext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_div   <= '0;
      q       <= '0;
      r       <= '0;
      dz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd <= w_zmag;
            r_div <= w_ymag;
            r_rem <= '0;
            r_cnt <= '0;
            if (y == '0) begin
              q       <= '1;
              r       <= '0;
              dz      <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rnext;
          r_dvd <= w_qnext;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            q       <= w_qfin;
            r       <= w_rfin;
            dz      <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - table-driven, scoreboard-checked bench for restoring_divider (WIDTH=4).
module tb_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] z;
  logic [3:0] y;
  logic [7:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       dz;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int k_edge = 0;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
  } exp_t;

  typedef struct {
    logic [7:0] z;
    logic [3:0] y;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  restoring_divider #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .z    (z),
    .y    (y),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dz   (dz)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic exp_t model(input logic [7:0] zz, input logic [3:0] yy);
    exp_t e;
    int zi, yi, qi, ri;
    if (yy == 4'd0) begin
      e.q = 8'hFF; e.r = 4'h0; e.dz = 1'b1; e.lat = 0;
      return e;
    end
`ifdef RESTORING_DIV_SIGNED_EN
    zi = int'($signed(zz));
    yi = int'($signed(yy));
`else
    zi = int'(zz);
    yi = int'(yy);
`endif
    qi = zi / yi;
    ri = zi % yi;
    e.q = qi[7:0]; e.r = ri[3:0]; e.dz = 1'b0; e.lat = 8;
    return e;
  endfunction

  // called at a negedge; returns 1 time unit after the start-sampling edge
  task automatic issue(input logic [7:0] zz, input logic [3:0] yy, input exp_t e);
    z = zz;
    y = yy;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    k_edge = cyc;
    start = 1'b0;
  endtask

  task automatic wait_check(input string tag);
    int n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout: done never rose within %0d cycles", tag, n);
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard: got empty queue want one entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, cyc - k_edge, e.lat);
    chk({tag, " q"}, {24'd0, q}, {24'd0, e.q});
    chk({tag, " r"}, {28'd0, r}, {28'd0, e.r});
    chk({tag, " dz"}, {31'd0, dz}, {31'd0, e.dz});
    chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, " q_hold"}, {24'd0, q}, {24'd0, e.q});
    chk({tag, " r_hold"}, {28'd0, r}, {28'd0, e.r});
  endtask

  initial begin
    exp_t e;
    logic [7:0] rz;
    logic [3:0] ry;

`ifdef RESTORING_DIV_SIGNED_EN
    vt.push_back('{8'h9C, 4'd7, 8'hF2, 4'hE, 1'b0, 8});
    vt.push_back('{8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 8});
    vt.push_back('{8'd9,  4'hD, 8'hFD, 4'h0, 1'b0, 8});
    vt.push_back('{8'hF9, 4'd2, 8'hFD, 4'hF, 1'b0, 8});
    vt.push_back('{8'd50, 4'd0, 8'hFF, 4'h0, 1'b1, 0});
    vt.push_back('{8'd9,  4'd3, 8'd3,  4'h0, 1'b0, 8});
`else
    vt.push_back('{8'd100, 4'd7,  8'd14,  4'd2, 1'b0, 8});
    vt.push_back('{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8});
    vt.push_back('{8'd15,  4'd15, 8'd1,   4'd0, 1'b0, 8});
    vt.push_back('{8'd50,  4'd0,  8'hFF,  4'd0, 1'b1, 0});
    vt.push_back('{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8});
    vt.push_back('{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 8});
    vt.push_back('{8'd7,   4'd9,  8'd0,   4'd7, 1'b0, 8});
`endif

    rst = 1'b1;
    start = 1'b0;
    z = 8'd0;
    y = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset q", {24'd0, q}, 32'd0);
    chk("reset r", {28'd0, r}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset dz", {31'd0, dz}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // consecutive entries are issued in the first idle cycle after each done pulse
    for (int i = 0; i < vt.size(); i++) begin
      e = '{vt[i].q, vt[i].r, vt[i].dz, vt[i].lat};
      issue(vt[i].z, vt[i].y, e);
      wait_check($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      rz = 8'($urandom);
      ry = 4'($urandom_range(0, 15));
      issue(rz, ry, model(rz, ry));
      wait_check($sformatf("rnd%0d_%0h_%0h", i, rz, ry));
    end

    // start while busy, and operand changes after the start edge, must not disturb the result
    issue(8'd100, 4'd7, '{8'd14, 4'd2, 1'b0, 8});
    repeat (3) @(negedge clk);
    z = 8'd200;
    y = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    z = 8'd5;
    y = 4'd1;
    wait_check("busy_ignore");

    // reset after four iterations, then a fresh operation
    issue(8'd100, 4'd7, '{8'd14, 4'd2, 1'b0, 8});
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    e = sb.pop_back();
    chk("midrst q", {24'd0, q}, 32'd0);
    chk("midrst r", {28'd0, r}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst dz", {31'd0, dz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst busy", {31'd0, busy}, 32'd0);
    issue(8'd9, 4'd3, '{8'd3, 4'd0, 1'b0, 8});
    wait_check("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
